bp_update_sched: RTL



---
 rtl/bp_update_sched.sv | 111 +++++++++++
 1 files changed

// File: rtl/bp_update_sched.sv
// Branch-predictor update scheduler: round-robin arbitration of two branch units
// into an in-order FIFO, issuing at most one registered update per cycle to the BP.
module bp_update_sched #(
    parameter int DEPTH = 4,
    parameter int GHR_W = 5,
    localparam int PW = 68 + GHR_W,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [PW-1:0]    req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [PW-1:0]    req1_data,
    output logic             is_branch_out,
    output logic             is_jump_out,
    output logic             is_taken_out,
    output logic             is_miss_out,
    output logic [GHR_W-1:0] last_pht_index_out,
    output logic [31:0]      inst_pc_out,
    output logic [31:0]      target_out,
    output logic [CW-1:0]    count_out,
    output logic [15:0]      miss_cnt_out
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          rr;
    logic [PW-1:0] out_q;
    logic [15:0]   miss_cnt;

    logic          full, gnt0, gnt1, enq, deq;
    logic [PW-1:0] enq_data, head;

    assign full     = (count == CW'(DEPTH));
    assign head     = mem[rd_ptr];
    assign enq      = gnt0 | gnt1;
    assign enq_data = gnt1 ? req1_data : req0_data;
    assign deq      = (count != '0) && !hold && !flush;

    // Grant is purely combinational; full comes from the registered count so a
    // same-cycle dequeue never opens a slot early.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !flush && !full) begin
            if (req0_valid && req1_valid) begin
                gnt0 = ~rr;
                gnt1 = rr;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr] <= enq_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rr       <= 1'b0;
            out_q    <= '0;
            miss_cnt <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            out_q  <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + AW'(1);
            if (deq)
                rd_ptr <= rd_ptr + AW'(1);
            if (enq && !deq)
                count <= count + CW'(1);
            else if (deq && !enq)
                count <= count - CW'(1);
            // Outputs are a one-cycle pulse; idle cycles drive zeros, never a repeat.
            out_q <= deq ? head : '0;
            if (deq && head[PW-4] && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
            if (req0_valid && req1_valid && enq)
                rr <= ~rr;
        end
    end

    assign is_branch_out      = out_q[PW-1];
    assign is_jump_out        = out_q[PW-2];
    assign is_taken_out       = out_q[PW-3];
    assign is_miss_out        = out_q[PW-4];
    assign last_pht_index_out = out_q[64 +: GHR_W];
    assign inst_pc_out        = out_q[63:32];
    assign target_out         = out_q[31:0];
    assign count_out          = count;
    assign miss_cnt_out       = miss_cnt;
endmodule
